// File: rtl/sentence_word_sequencer_pkg.sv
// Shared definitions for the sentence word sequencer: sizes, FSM states and
// helpers that pick one word or one length out of a packed ROM sentence.
package sentence_word_sequencer_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned N_WORDS = 8;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned SENT_W  = WORD_W * N_WORDS;
  localparam int unsigned LENS_W  = LEN_W * N_WORDS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SHOW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Word k occupies the k-th 32-bit slot counted from the MSB end.
  function automatic logic [WORD_W-1:0] word_at(input logic [SENT_W-1:0] s,
                                                input logic [IDX_W-1:0]  idx);
    word_at = '0;
    for (int unsigned k = 0; k < N_WORDS; k++) begin
      if (idx == IDX_W'(k)) word_at = s[SENT_W-1-WORD_W*k -: WORD_W];
    end
  endfunction

  // Length k occupies the k-th 3-bit slot counted from the MSB end.
  function automatic logic [LEN_W-1:0] len_at(input logic [LENS_W-1:0] l,
                                              input logic [IDX_W-1:0]  idx);
    len_at = '0;
    for (int unsigned k = 0; k < N_WORDS; k++) begin
      if (idx == IDX_W'(k)) len_at = l[LENS_W-1-LEN_W*k -: LEN_W];
    end
  endfunction

endpackage

// File: rtl/sentence_word_sequencer_dwell_timer.sv
// Dwell timer: counts 0..DWELL_CYCLES-1 while enabled and flags the last
// cycle of each dwell period, wrapping to 0 on its own.
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign tc = enable && (count == LAST);

  // Count up while enabled; clear or terminal count returns to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sentence_word_sequencer.sv
// Steps through one 8-word sentence from the sentence ROM, presenting each
// word and its length for a fixed dwell time, then pulses done.
module sentence_word_sequencer
  import sentence_word_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              next_sentence,
  input  logic              abort,
  output logic [ADDR_W-1:0] sentence_addr,
  input  logic [SENT_W-1:0] sentence,
  input  logic [LENS_W-1:0] cursor_positions,
  output logic [WORD_W-1:0] word_out,
  output logic [LEN_W-1:0]  word_len,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  output logic              busy,
  output logic              done
);

  state_t              state;
  logic [SENT_W-1:0]   sentence_q;
  logic [LENS_W-1:0]   lens_q;
  logic                tc;
  logic                timer_clear;
  logic                timer_en;

  assign timer_en    = (state == S_SHOW);
  assign timer_clear = (state != S_SHOW) || abort;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES),
    .CNT_W       (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .enable(timer_en),
    .tc    (tc)
  );

  // Sequencer FSM with registered status outputs; abort outranks every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      sentence_addr <= '0;
      sentence_q    <= '0;
      lens_q        <= '0;
      word_idx      <= '0;
      word_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end else if (next_sentence) begin
            sentence_addr <= sentence_addr + ADDR_W'(1);
          end
        end
        S_LOAD: begin
          sentence_q <= sentence;
          lens_q     <= cursor_positions;
          word_idx   <= '0;
          if (len_at(cursor_positions, '0) == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state      <= S_SHOW;
            word_valid <= 1'b1;
          end
        end
        S_SHOW: begin
          if (tc) begin
            if (word_idx == IDX_W'(N_WORDS - 1) ||
                len_at(lens_q, word_idx + IDX_W'(1)) == '0) begin
              state      <= S_DONE;
              word_valid <= 1'b0;
              done       <= 1'b1;
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          word_idx <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Word and length come from the latched sentence, blanked outside SHOW.
  always_comb begin
    word_out = '0;
    word_len = '0;
    if (word_valid) begin
      word_out = word_at(sentence_q, word_idx);
      word_len = len_at(lens_q, word_idx);
    end
  end

endmodule

// File: tb/tb_sentence_word_sequencer.sv
// Directed bench for sentence_word_sequencer with a 4-cycle dwell and a
// small behavioural sentence ROM driven from sentence_addr.
module tb_sentence_word_sequencer;

  localparam int unsigned DWELL = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          next_sentence;
  logic          abort;
  logic [1:0]    sentence_addr;
  logic [255:0]  sentence;
  logic [23:0]   cursor_positions;
  logic [31:0]   word_out;
  logic [2:0]    word_len;
  logic [2:0]    word_idx;
  logic          word_valid;
  logic          busy;
  logic          done;

  logic [31:0]   words [4][8];
  logic [2:0]    lens  [4][8];
  logic [255:0]  rom_s [4];
  logic [23:0]   rom_l [4];
  logic [255:0]  save_s;
  logic [23:0]   save_l;

  int unsigned   n_checks;
  int unsigned   n_fail;

  assign sentence         = rom_s[sentence_addr];
  assign cursor_positions = rom_l[sentence_addr];

  sentence_word_sequencer #(
    .DWELL_CYCLES(DWELL),
    .CNT_W       (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .next_sentence   (next_sentence),
    .abort           (abort),
    .sentence_addr   (sentence_addr),
    .sentence        (sentence),
    .cursor_positions(cursor_positions),
    .word_out        (word_out),
    .word_len        (word_len),
    .word_idx        (word_idx),
    .word_valid      (word_valid),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [1:0] addr);
    check({tag, "_addr"},  32'(sentence_addr), 32'(addr));
    check({tag, "_word"},  word_out, 32'h0);
    check({tag, "_len"},   32'(word_len), 32'd0);
    check({tag, "_idx"},   32'(word_idx), 32'd0);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
  endtask

  task automatic pulse_next(input int unsigned count);
    for (int unsigned i = 0; i < count; i++) begin
      next_sentence = 1'b1;
      tick();
      next_sentence = 1'b0;
    end
  endtask

  // Start a sentence at address a and follow it word by word through DONE.
  task automatic run_sentence(input int unsigned a, input int unsigned n,
                              input bit with_next, input bit noise);
    start         = 1'b1;
    next_sentence = with_next;
    tick();
    start         = 1'b0;
    next_sentence = 1'b0;
    check("load_busy",  32'(busy), 32'd1);
    check("load_valid", 32'(word_valid), 32'd0);
    check("load_addr",  32'(sentence_addr), a);
    tick();
    if (noise) begin
      save_s   = rom_s[a];
      save_l   = rom_l[a];
      rom_s[a] = ~save_s;
      rom_l[a] = '0;
    end
    for (int unsigned k = 0; k < n; k++) begin
      for (int unsigned c = 0; c < DWELL; c++) begin
        if (noise) begin
          start         = (c % 2 == 0);
          next_sentence = (c % 2 == 1);
        end
        check("show_word",  word_out, words[a][k]);
        check("show_len",   32'(word_len), 32'(lens[a][k]));
        check("show_idx",   32'(word_idx), k);
        check("show_valid", 32'(word_valid), 32'd1);
        check("show_busy",  32'(busy), 32'd1);
        check("show_done",  32'(done), 32'd0);
        tick();
      end
    end
    start         = 1'b0;
    next_sentence = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_valid", 32'(word_valid), 32'd0);
    check("done_word",  word_out, 32'h0);
    check("done_busy",  32'(busy), 32'd1);
    tick();
    check_idle("after_done", 2'(a));
    if (noise) begin
      rom_s[a] = save_s;
      rom_l[a] = save_l;
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    start         = 1'b0;
    next_sentence = 1'b0;
    abort         = 1'b0;

    words[0] = '{32'h11223344, 32'h22334455, 32'h33445566, 32'h44556677,
                 32'h55667788, 32'h0, 32'h0, 32'h0};
    lens[0]  = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0};
    words[1] = '{32'hA1A2A3A4, 32'hB1B2B300, 32'hC1000000, 32'hD1D20000,
                 32'h0, 32'h0, 32'h0, 32'h0};
    lens[1]  = '{3'd5, 3'd7, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    words[2] = '{32'h2A2B2C00, 32'h2D2E0000, 32'h3A3B3C00, 32'h3D3E0000,
                 32'h4A4B4C00, 32'h4D4E4F40, 32'h5A5B0000, 32'h32242300};
    lens[2]  = '{3'd3, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd2, 3'd4};
    words[3] = '{32'h2C33431B, 32'h431B0000, 32'h2B442D00, 32'h1C000000,
                 32'h333C3424, 32'h31242D23, 32'hDEADBEEF, 32'h12345678};
    lens[3]  = '{3'd4, 3'd2, 3'd3, 3'd1, 3'd4, 3'd4, 3'd0, 3'd0};
    for (int unsigned a = 0; a < 4; a++) begin
      rom_s[a] = {words[a][0], words[a][1], words[a][2], words[a][3],
                  words[a][4], words[a][5], words[a][6], words[a][7]};
      rom_l[a] = {lens[a][0], lens[a][1], lens[a][2], lens[a][3],
                  lens[a][4], lens[a][5], lens[a][6], lens[a][7]};
    end

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset", 2'd0);

    // Sentence 3: six words, stops at the zero-length seventh
    pulse_next(3);
    check("addr_after_3", 32'(sentence_addr), 32'd3);
    run_sentence(3, 6, 1'b0, 1'b0);

    // Sentence 2: all eight words, then again with start/next noise and ROM changes
    pulse_next(3);
    check("addr_wrap_to_2", 32'(sentence_addr), 32'd2);
    run_sentence(2, 8, 1'b0, 1'b0);
    run_sentence(2, 8, 1'b0, 1'b1);

    // Address wrap from reset, start beats next_sentence, lengths 5/7 pass through
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_next(5);
    check("addr_after_5", 32'(sentence_addr), 32'd1);
    run_sentence(1, 2, 1'b1, 1'b0);

    // Abort during word 3 of sentence 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned i = 0; i < 1 + 3 * DWELL + 1; i++) tick();
    check("pre_abort_idx",   32'(word_idx), 32'd3);
    check("pre_abort_valid", 32'(word_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort", 2'd0);
    tick();
    check("abort_no_done", 32'(done), 32'd0);

    // Abort and start together in IDLE: abort wins
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);
    tick();
    check("abort_start_busy2", 32'(busy), 32'd0);

    // Restart after abort begins at word 0
    run_sentence(0, 5, 1'b0, 1'b0);

    // Zero-length first word: LOAD goes straight to DONE
    save_l   = rom_l[0];
    rom_l[0] = {3'd0, save_l[20:0]};
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_load_busy", 32'(busy), 32'd1);
    tick();
    check("zero_done",  32'(done), 32'd1);
    check("zero_valid", 32'(word_valid), 32'd0);
    check("zero_len",   32'(word_len), 32'd0);
    tick();
    check_idle("zero_after", 2'd0);
    rom_l[0] = save_l;

    // Reset mid-SHOW
    pulse_next(2);
    check("addr_pre_rst", 32'(sentence_addr), 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned i = 0; i < 6; i++) tick();
    check("pre_rst_valid", 32'(word_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_show_rst", 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
